// File: rtl/e203_exu_wbck_arb.sv
// Write-back arbiter: merges ALU results and FIFO-buffered long-pipe results into one registered regfile write.
// Optional macro E203_WBCK_ARB_PERF_EN adds saturating per-source write-back counters.
module e203_exu_wbck_arb #(
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int FIFO_DEPTH = 2,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_wbck_i_valid,
  output logic               alu_wbck_i_ready,
  input  logic [XLEN-1:0]    alu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
  input  logic               lpipe_wbck_i_valid,
  output logic               lpipe_wbck_i_ready,
  input  logic [XLEN-1:0]    lpipe_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] lpipe_wbck_i_rdidx,
  output logic               wbck_dest_wen,
  output logic [RFIDX_W-1:0] wbck_dest_idx,
  output logic [XLEN-1:0]    wbck_dest_dat,
  output logic [CNT_W-1:0]   lpipe_fifo_cnt,
`ifdef E203_WBCK_ARB_PERF_EN
  output logic [31:0]        perf_alu_cnt,
  output logic [31:0]        perf_lpipe_cnt,
`endif
  output logic               wbck_busy
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // Both readies are decoded from the registered FIFO count only, so they never depend on valid.

  logic [XLEN-1:0]    fifo_dat [FIFO_DEPTH];
  logic [RFIDX_W-1:0] fifo_idx [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   cnt;

  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;

  logic               grant_vld;
  logic [RFIDX_W-1:0] grant_idx;
  logic [XLEN-1:0]    grant_dat;
  logic               grant_wr;

  assign fifo_empty         = (cnt == '0);
  assign fifo_full          = (cnt == CNT_W'(FIFO_DEPTH));
  assign lpipe_wbck_i_ready = !fifo_full;
  assign alu_wbck_i_ready   = fifo_empty;
  assign push               = lpipe_wbck_i_valid & lpipe_wbck_i_ready;
  assign pop                = !fifo_empty;

  // The FIFO head always wins; a just-pushed entry is only visible from the next cycle.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = alu_wbck_i_rdidx;
    grant_dat = alu_wbck_i_wdat;
    if (!fifo_empty) begin
      grant_vld = 1'b1;
      grant_idx = fifo_idx[rd_ptr];
      grant_dat = fifo_dat[rd_ptr];
    end else if (alu_wbck_i_valid) begin
      grant_vld = 1'b1;
    end
  end

  // x0 writes are consumed but never reach the regfile port.
  assign grant_wr = grant_vld & (grant_idx != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dat[wr_ptr] <= lpipe_wbck_i_wdat;
      fifo_idx[wr_ptr] <= lpipe_wbck_i_rdidx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbck_dest_wen <= 1'b0;
      wbck_dest_idx <= '0;
      wbck_dest_dat <= '0;
    end else begin
      wbck_dest_wen <= grant_wr;
      if (grant_wr) begin
        wbck_dest_idx <= grant_idx;
        wbck_dest_dat <= grant_dat;
      end
    end
  end

  assign lpipe_fifo_cnt = cnt;
  assign wbck_busy      = !fifo_empty | wbck_dest_wen;

`ifdef E203_WBCK_ARB_PERF_EN
  logic [31:0] perf_alu_q;
  logic [31:0] perf_lpipe_q;
  logic        grant_lpipe;

  assign grant_lpipe = !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_alu_q   <= '0;
      perf_lpipe_q <= '0;
    end else begin
      if (grant_wr && !grant_lpipe && !(&perf_alu_q))  perf_alu_q   <= perf_alu_q + 32'd1;
      if (grant_wr &&  grant_lpipe && !(&perf_lpipe_q)) perf_lpipe_q <= perf_lpipe_q + 32'd1;
    end
  end

  assign perf_alu_cnt   = perf_alu_q;
  assign perf_lpipe_cnt = perf_lpipe_q;
`endif

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Bench for e203_exu_wbck_arb: per-cycle vector table, an in-order long-pipe stream with an expected queue,
// and (with E203_WBCK_ARB_PERF_EN) the performance counters.
module tb_e203_exu_wbck_arb;

  logic        clk;
  logic        rst_n;
  logic        alu_wbck_i_valid;
  logic        alu_wbck_i_ready;
  logic [31:0] alu_wbck_i_wdat;
  logic [4:0]  alu_wbck_i_rdidx;
  logic        lpipe_wbck_i_valid;
  logic        lpipe_wbck_i_ready;
  logic [31:0] lpipe_wbck_i_wdat;
  logic [4:0]  lpipe_wbck_i_rdidx;
  logic        wbck_dest_wen;
  logic [4:0]  wbck_dest_idx;
  logic [31:0] wbck_dest_dat;
  logic [1:0]  lpipe_fifo_cnt;
  logic        wbck_busy;
`ifdef E203_WBCK_ARB_PERF_EN
  logic [31:0] perf_alu_cnt;
  logic [31:0] perf_lpipe_cnt;
`endif

  int checks = 0;
  int errors = 0;

  e203_exu_wbck_arb dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .alu_wbck_i_valid   (alu_wbck_i_valid),
    .alu_wbck_i_ready   (alu_wbck_i_ready),
    .alu_wbck_i_wdat    (alu_wbck_i_wdat),
    .alu_wbck_i_rdidx   (alu_wbck_i_rdidx),
    .lpipe_wbck_i_valid (lpipe_wbck_i_valid),
    .lpipe_wbck_i_ready (lpipe_wbck_i_ready),
    .lpipe_wbck_i_wdat  (lpipe_wbck_i_wdat),
    .lpipe_wbck_i_rdidx (lpipe_wbck_i_rdidx),
    .wbck_dest_wen      (wbck_dest_wen),
    .wbck_dest_idx      (wbck_dest_idx),
    .wbck_dest_dat      (wbck_dest_dat),
    .lpipe_fifo_cnt     (lpipe_fifo_cnt),
`ifdef E203_WBCK_ARB_PERF_EN
    .perf_alu_cnt       (perf_alu_cnt),
    .perf_lpipe_cnt     (perf_lpipe_cnt),
`endif
    .wbck_busy          (wbck_busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ai;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  li;
    logic [31:0] ld;
    logic        ew;
    logic [4:0]  ei;
    logic [31:0] ed;
    logic [1:0]  ec;
    logic        ear;
    logic        elr;
    logic        eb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic av, logic [4:0] ai, logic [31:0] ad,
                              logic lv, logic [4:0] li, logic [31:0] ld,
                              logic ew, logic [4:0] ei, logic [31:0] ed, logic [1:0] ec,
                              logic ear, logic elr, logic eb);
    vec_t v;
    v.rst = rst; v.av = av; v.ai = ai; v.ad = ad; v.lv = lv; v.li = li; v.ld = ld;
    v.ew = ew; v.ei = ei; v.ed = ed; v.ec = ec; v.ear = ear; v.elr = elr; v.eb = eb;
    return v;
  endfunction

  // Driver tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic av, input logic [4:0] ai, input logic [31:0] ad,
                       input logic lv, input logic [4:0] li, input logic [31:0] ld);
    rst_n              = rst;
    alu_wbck_i_valid   = av;
    alu_wbck_i_rdidx   = ai;
    alu_wbck_i_wdat    = ad;
    lpipe_wbck_i_valid = lv;
    lpipe_wbck_i_rdidx = li;
    lpipe_wbck_i_wdat  = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the long-pipe stream: {idx, dat} in push order plus push cycle
  logic [36:0] exp_q[$];
  int          exp_t[$];

  initial begin
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // rst, av, ai, ad, lv, li, ld  ->  wen, idx, dat, cnt, alu_rdy, lp_rdy, busy
    vecs.push_back(mk(0, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      0, 5'd0,  32'h0,    2'd0, 1, 1, 0));
    vecs.push_back(mk(1, 1, 5'd5,  32'h1234, 0, 5'd0,  32'h0,      1, 5'd5,  32'h1234, 2'd0, 1, 1, 1));
    vecs.push_back(mk(1, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      0, 5'd5,  32'h1234, 2'd0, 1, 1, 0));
    vecs.push_back(mk(1, 1, 5'd3,  32'h3333, 1, 5'd7,  32'hA5A5,   1, 5'd3,  32'h3333, 2'd1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      1, 5'd7,  32'hA5A5, 2'd0, 1, 1, 1));
    vecs.push_back(mk(1, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      0, 5'd7,  32'hA5A5, 2'd0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 5'd0,  32'h0,    1, 5'd10, 32'hA0,     0, 5'd7,  32'hA5A5, 2'd1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 5'd9,  32'h9999, 1, 5'd11, 32'hB0,     1, 5'd10, 32'hA0,   2'd1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 5'd9,  32'h9999, 1, 5'd12, 32'hC0,     1, 5'd11, 32'hB0,   2'd1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 5'd9,  32'h9999, 0, 5'd0,  32'h0,      1, 5'd12, 32'hC0,   2'd0, 1, 1, 1));
    vecs.push_back(mk(1, 1, 5'd9,  32'h9999, 0, 5'd0,  32'h0,      1, 5'd9,  32'h9999, 2'd0, 1, 1, 1));
    vecs.push_back(mk(1, 1, 5'd0,  32'hFFFF, 0, 5'd0,  32'h0,      0, 5'd9,  32'h9999, 2'd0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 5'd0,  32'h0,    1, 5'd0,  32'hDEAD,   0, 5'd9,  32'h9999, 2'd1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      0, 5'd9,  32'h9999, 2'd0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 5'd0,  32'h0,    1, 5'd13, 32'hD0,     0, 5'd9,  32'h9999, 2'd1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 5'd15, 32'hF0,   1, 5'd14, 32'hE0,     0, 5'd0,  32'h0,    2'd0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      0, 5'd0,  32'h0,    2'd0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      0, 5'd0,  32'h0,    2'd0, 1, 1, 0));

    tick();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].ai, vecs[i].ad, vecs[i].lv, vecs[i].li, vecs[i].ld);
      tick();
      chk($sformatf("v%0d_wen", i),     {31'd0, wbck_dest_wen},      {31'd0, vecs[i].ew});
      chk($sformatf("v%0d_idx", i),     {27'd0, wbck_dest_idx},      {27'd0, vecs[i].ei});
      chk($sformatf("v%0d_dat", i),     wbck_dest_dat,               vecs[i].ed);
      chk($sformatf("v%0d_cnt", i),     {30'd0, lpipe_fifo_cnt},     {30'd0, vecs[i].ec});
      chk($sformatf("v%0d_alu_rdy", i), {31'd0, alu_wbck_i_ready},   {31'd0, vecs[i].ear});
      chk($sformatf("v%0d_lp_rdy", i),  {31'd0, lpipe_wbck_i_ready}, {31'd0, vecs[i].elr});
      chk($sformatf("v%0d_busy", i),    {31'd0, wbck_busy},          {31'd0, vecs[i].eb});
    end

    // Long-pipe stream with random gaps: order, data and minimum latency
    for (int c = 0; c < 60; c++) begin
      logic       lv;
      logic [4:0] li;
      logic [31:0] ld;
      logic       pushed;
      lv = (c < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      li = 5'($urandom_range(1, 31));
      ld = $urandom;
      drive(1'b1, 1'b0, 5'd0, 32'd0, lv, li, ld);
      chk("stream_lp_rdy", {31'd0, lpipe_wbck_i_ready}, 32'd1);
      pushed = lv & lpipe_wbck_i_ready;
      tick();
      if (wbck_dest_wen) begin
        if (exp_q.size() == 0) begin
          chk("stream_unexpected_wen", 32'd1, 32'd0);
        end else begin
          logic [36:0] e;
          int          t;
          e = exp_q.pop_front();
          t = exp_t.pop_front();
          chk("stream_idx", {27'd0, wbck_dest_idx}, {27'd0, e[36:32]});
          chk("stream_dat", wbck_dest_dat, e[31:0]);
          if (c - t + 1 < 2) chk("stream_latency", c - t + 1, 32'd2);
        end
      end
      if (pushed) begin
        exp_q.push_back({li, ld});
        exp_t.push_back(c);
      end
    end
    chk("stream_drained", exp_q.size(), 32'd0);

`ifdef E203_WBCK_ARB_PERF_EN
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    chk("perf_alu_reset", perf_alu_cnt, 32'd0);
    chk("perf_lpipe_reset", perf_lpipe_cnt, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 32'd0);
      tick();
    end
    drive(1'b1, 1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'(20 + i), 32'h50 + 32'(i));
      tick();
      drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
    end
    tick();
    chk("perf_alu_cnt", perf_alu_cnt, 32'd4);
    chk("perf_lpipe_cnt", perf_lpipe_cnt, 32'd2);
    force dut.perf_alu_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.perf_alu_q;
    drive(1'b1, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    chk("perf_alu_saturate", perf_alu_cnt, 32'hFFFF_FFFF);
`endif

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
